// File: rtl/mmio_display_responder.sv
`timescale 1ns/1ps
// MMIO responder for the CPU's I/O space: LED register, four-digit seven-segment
// display with multiplexed scan, and an optional systick counter (DISP_SYSTICK_EN).
module mmio_display_responder #(
  parameter logic [31:0] LED_ADDR   = 32'h4000_000C,
  parameter logic [31:0] DIGIT_ADDR = 32'h4000_0010,
  parameter logic [31:0] TICK_ADDR  = 32'h4000_0014,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_wr,
  input  logic        mem_rd,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic [11:0] leds,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] p;
    unique case (v)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

  // Address decode: word compare only, the byte offset is ignored.
  logic led_sel;
  logic digit_sel;
  logic tick_match;
  logic tick_sel;

  assign led_sel    = (addr[31:2] == LED_ADDR[31:2]);
  assign digit_sel  = (addr[31:2] == DIGIT_ADDR[31:2]);
  assign tick_match = (addr[31:2] == TICK_ADDR[31:2]);

  logic [11:0] led_reg;
  logic [19:0] digit_reg;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_reg   <= '0;
      digit_reg <= '0;
    end else if (mem_wr) begin
      if (led_sel)   led_reg   <= wdata[11:0];
      if (digit_sel) digit_reg <= wdata[19:0];
    end
  end

  assign leds = led_reg;

`ifdef DISP_SYSTICK_EN
  logic [31:0] systick;

  assign tick_sel = tick_match;

  // A store wins over the free-running increment for that cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      systick <= '0;
    end else if (mem_wr && tick_sel) begin
      systick <= wdata;
    end else begin
      systick <= systick + 32'd1;
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{mem_rd, addr[1:0]};
`else
  assign tick_sel = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{mem_rd, addr[1:0], tick_match, wdata[31:20]};
`endif

  assign hit = led_sel | digit_sel | tick_sel;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rdata = '0;
    if (led_sel) begin
      rdata = {20'b0, led_reg};
    end else if (digit_sel) begin
      rdata = {12'b0, digit_reg};
`ifdef DISP_SYSTICK_EN
    end else if (tick_sel) begin
      rdata = systick;
`endif
    end
  end

  // Digit scan: the pattern for the next slot is loaded on the same edge as its anode.
  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       idx;
  logic [1:0]       idx_next;
  logic             scan_wrap;
  logic [3:0]       nib_next;
  logic             dp_next;
  logic [3:0]       dp_bits;

  assign scan_wrap = (scan_cnt == SCAN_LAST);
  assign idx_next  = idx + 2'd1;
  assign dp_bits   = digit_reg[19:16];
  assign dp_next   = dp_bits[idx_next];

  always_comb begin
    nib_next = digit_reg[3:0];
    unique case (idx_next)
      2'd0: nib_next = digit_reg[3:0];
      2'd1: nib_next = digit_reg[7:4];
      2'd2: nib_next = digit_reg[11:8];
      default: nib_next = digit_reg[15:12];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      idx      <= '0;
      an       <= 4'hF;
      seg      <= 8'hFF;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      idx      <= idx_next;
      an       <= ~(4'b0001 << idx_next);
      seg      <= ~{dp_next, hex7(nib_next)};
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

endmodule
